// File: rtl/dmem_responder_pkg.sv
// Shared data-memory bus definitions used by both the initiator and the responder.
`default_nettype none

package dmem_responder_pkg;

    localparam logic MEMREQ_READ  = 1'b0;
    localparam logic MEMREQ_WRITE = 1'b1;

    typedef struct packed {
        logic        mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } memreq_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// Word-addressed synchronous RAM with byte-lane write enables (read-first, BRAM style).
`default_nettype none

module dmem_array #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        wstrb,
    input  logic [ADDR_W-1:0] index,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && wstrb[i]) begin
                mem[index][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[index];
    end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// Data-memory bus responder: one request in service, one pending, fixed access latency.
`default_nettype none

module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        request_enable,
    input  logic        mode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        response_enable,
    output logic [31:0] data,
    output logic        busy,
    output logic        err
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t      state, state_nx;
    memreq_t     cur_req, cur_nx;
    memreq_t     pend_req, pend_nx;
    memreq_t     in_req;
    logic        pend_valid, pend_valid_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        rd_ok, rd_ok_nx;
    logic        err_r, err_nx;
    logic [31:0] data_hold;
    logic [31:0] rdata;
    logic        oor;
    logic        access;
    logic        we;
    logic        unused_addr_bits;

    assign in_req = {mode, addr, wdata, wstrb};

    assign oor    = |cur_req.addr[31:ADDR_W+2];
    assign access = (state == WAIT) && (cnt == 4'd0);
    // Gating with rstn keeps a reset that lands on the access edge from committing the write.
    assign we     = access && rstn && (cur_req.mode == MEMREQ_WRITE) && !oor;

    assign unused_addr_bits = ^cur_req.addr[1:0];

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .wstrb (cur_req.wstrb),
        .index (cur_req.addr[ADDR_W+1:2]),
        .wdata (cur_req.wdata),
        .rdata (rdata)
    );

    always_comb begin
        state_nx      = state;
        cur_nx        = cur_req;
        pend_nx       = pend_req;
        pend_valid_nx = pend_valid;
        cnt_nx        = cnt;
        rd_ok_nx      = rd_ok;
        err_nx        = err_r;
        case (state)
            IDLE: begin
                if (request_enable) begin
                    cur_nx   = in_req;
                    cnt_nx   = CNT_INIT;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_nx = cnt - 4'd1;
                end else begin
                    state_nx = RESP;
                    rd_ok_nx = (cur_req.mode == MEMREQ_READ) && !oor;
                    if (oor) err_nx = 1'b1;
                end
                if (request_enable) begin
                    if (pend_valid) begin
                        err_nx = 1'b1;
                    end else begin
                        pend_nx       = in_req;
                        pend_valid_nx = 1'b1;
                    end
                end
            end
            RESP: begin
                // A request arriving now either refills the pending slot or goes straight into service.
                if (pend_valid) begin
                    cur_nx   = pend_req;
                    cnt_nx   = CNT_INIT;
                    state_nx = WAIT;
                    if (request_enable) pend_nx = in_req;
                    else                pend_valid_nx = 1'b0;
                end else if (request_enable) begin
                    cur_nx   = in_req;
                    cnt_nx   = CNT_INIT;
                    state_nx = WAIT;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            cur_req    <= '0;
            pend_req   <= '0;
            pend_valid <= 1'b0;
            cnt        <= 4'd0;
            rd_ok      <= 1'b0;
            err_r      <= 1'b0;
            data_hold  <= 32'd0;
        end else begin
            state      <= state_nx;
            cur_req    <= cur_nx;
            pend_req   <= pend_nx;
            pend_valid <= pend_valid_nx;
            cnt        <= cnt_nx;
            rd_ok      <= rd_ok_nx;
            err_r      <= err_nx;
            if (state == RESP) data_hold <= data;
        end
    end

    assign response_enable = (state == RESP);
    assign data            = (state == RESP) ? (rd_ok ? rdata : 32'd0) : data_hold;
    assign busy            = (state != IDLE) || pend_valid;
    assign err             = err_r;

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the core's data-memory bus: accepts single-word read/write requests from the memory stage (request_enable, mode, addr, wdata, wstrb) and returns a one-cycle response_enable pulse with read data.
- Backed by an internal word-addressed array with byte-lane write strobes and a configurable access latency.
- One request in service plus a one-entry pending buffer; overflow and out-of-range accesses are flagged.
- Sits between the mem stage and the data RAM; later replaceable by a cache with the same interface.

Parameters:
- ADDR_W, 12, word-address width; the array holds 2**ADDR_W 32-bit words.
- LATENCY, 2, cycles from acceptance to the response pulse; legal range is 1 to 15.

Ports:
- clk  in  1  clock; all logic on posedge.
- rstn  in  1  reset, synchronous, active-low.
- request_enable  in  1  one-cycle pulse: a request is present this cycle.
- mode  in  1  MEMREQ_READ or MEMREQ_WRITE.
- addr  in  32  byte address, word-aligned by the initiator; addr[1:0] ignored.
- wdata  in  32  write data, already lane-positioned.
- wstrb  in  4  byte-lane enables, bit i selects wdata[8i+7:8i]; ignored on read.
- response_enable  out  1  one-cycle pulse: request complete.
- data  out  32  read data, valid while response_enable=1; held until the next response.
- busy  out  1  high while a request is in service or pending.
- err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (rstn=0 at posedge): response_enable=0, data=0, busy=0, err=0, state=IDLE, pending buffer empty, counter=0. Array contents are not reset.
- Request fields are sampled only in a cycle where request_enable=1. They are copied into cur_req (service) or pend_req (pending) and are never re-read from the ports afterwards.
- State IDLE:
  - request_enable=1: capture into cur_req, counter=LATENCY-1, go to WAIT.
  - busy rises the next cycle.
- State WAIT:
  - counter>0: decrement counter.
  - counter==0: perform the access and go to RESP.
  - The response pulse therefore appears exactly LATENCY cycles after the acceptance edge. Example: with LATENCY=2, a request at edge T gives response_enable=1 during cycle T+2.
- Access, performed in the WAIT→RESP transition:
  - Word index = cur_req.addr[ADDR_W+1:2].
  - Out of range if cur_req.addr[31:ADDR_W+2] != 0.
  - Read: data <= array[index], or 0 if out of range.
  - Write: for each lane i with wstrb[i]=1, write array[index] lane i; other lanes are unchanged. data <= 0.
  - Out-of-range write: array untouched, data <= 0.
  - Any out-of-range access sets err=1.
- State RESP (response_enable=1 for exactly this cycle):
  - Pending buffer valid: move pend_req to cur_req, clear the pending buffer, counter=LATENCY-1, go to WAIT.
  - Otherwise go to IDLE.
- Requests arriving while state != IDLE:
  - Pending buffer empty: capture into pend_req.
  - Pending buffer full: request dropped, err=1, no response is ever generated for it.
  - A request arriving in the RESP cycle while pend_req is being consumed is captured into the pending buffer in the same cycle; no drop.
- busy = (state != IDLE) OR pending buffer valid.
- Ordering: responses are issued in acceptance order. A read following a write to the same word returns the merged written value.
- Reset mid-operation: in-flight and pending requests are discarded and no response is issued. Array writes already performed persist.
- Back-to-back request_enable pulses in IDLE: the first is accepted, the second goes to the pending buffer.

Decomposition:
- Shared package (def.sv): MEMREQ_READ=1'b0, MEMREQ_WRITE=1'b1; typedef memreq_t {mode, addr[31:0], wdata[31:0], wstrb[3:0]}, used by both the initiator and the responder.
- Local localparams: IDLE, WAIT, RESP.
- One sub-module: dmem_array (ADDR_W; ports clk, we, wstrb, index, wdata, rdata), a synchronous byte-enable RAM that infers BRAM. The FSM, counter and pending buffer stay in dmem_responder.

Test Plan:
- Write then read, LATENCY=2:
  - Write addr=0x10, wdata=0xDEADBEEF, wstrb=4'b1111 → response_enable pulse 2 cycles after acceptance, data=0.
  - Read addr=0x10 → data=0xDEADBEEF.
- Byte strobes:
  - Write addr=0x10, wdata=0x00AA0000, wstrb=4'b0100, then read addr=0x10 → 0xDEAABEEF.
  - Write wdata=0x12000000, wstrb=4'b1000, then read → 0x12AABEEF.
- Pending buffer:
  - Read 0x10 at T, write 0x14 at T+1, read 0x14 at T+2 → third request dropped, err=1.
  - Exactly two responses: read data=0x12AABEEF, then write data=0; busy falls after the second.
- Out of range: read addr=0x0001_0000 with ADDR_W=12 → data=0, err=1, array unchanged.
- Reset mid-operation: accept a write, assert rstn=0 before the response → no response_enable pulse, busy=0, err=0. After reset, a read of that word returns its prior contents.
- Streaming, LATENCY=1:
  - Issue each new request in the cycle of the previous response, 8 reads of 0x0..0x1C → 8 in-order pulses, no drops, err stays 0.
